// File: rtl/ysyx_25060166_lsu.sv
// ysyx_25060166_lsu: RV32E load/store unit between the core and a
// word-addressed valid/ready memory bus with byte strobes.
module ysyx_25060166_lsu #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_wen,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [WIDTH-1:0] mem_addr,
    output logic             mem_wen,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic             mem_resp_valid,
    input  logic [WIDTH-1:0] mem_resp_rdata,
    input  logic             mem_resp_err
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_t;

    localparam logic [7:0] TO_LIMIT = TIMEOUT[7:0];

    state_t state;
    state_t state_n;

    logic [7:0] cnt;
    logic       expired;

    logic       lat_wen;
    logic [2:0] lat_f3;
    logic [1:0] lat_off;

    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic [3:0]       wstrb_q;
    logic             wen_q;
    logic [WIDTH-1:0] rdata_q;
    logic             err_q;

    logic             accept;
    logic             bad;
    logic [3:0]       st_strb;
    logic [WIDTH-1:0] st_data;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] ld_data;

    assign accept     = (state == IDLE) && req_valid;
    assign expired    = (cnt == TO_LIMIT);

    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_wstrb  = wstrb_q;
    assign mem_wen    = wen_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // Flag illegal funct3 encodings and misaligned halfword/word accesses.
    always_comb begin
        bad = 1'b0;
        unique case (req_funct3)
            3'b000:         bad = 1'b0;
            3'b001:         bad = req_addr[0];
            3'b010:         bad = |req_addr[1:0];
            3'b100, 3'b101: bad = req_wen | (req_funct3[0] & req_addr[0]);
            default:        bad = 1'b1;
        endcase
    end

    // Place store data on its byte lanes and build the matching strobes.
    always_comb begin
        st_strb = 4'b1111;
        st_data = req_wdata;
        unique case (req_funct3[1:0])
            2'b00: begin
                st_strb = 4'b0001 << req_addr[1:0];
                st_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                st_strb = 4'b0011 << req_addr[1:0];
                st_data = {2{req_wdata[15:0]}};
            end
            default: begin
                st_strb = 4'b1111;
                st_data = req_wdata;
            end
        endcase
    end

    // Pull the addressed lane out of the bus word and extend it.
    always_comb begin
        shifted = mem_resp_rdata >> {lat_off, 3'b000};
        ld_data = shifted;
        unique case (lat_f3)
            3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  ld_data = {24'd0, shifted[7:0]};
            3'b101:  ld_data = {16'd0, shifted[15:0]};
            default: ld_data = shifted;
        endcase
        if (lat_wen || mem_resp_err) begin
            ld_data = '0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic and handshake strobes decoded from the state.
    always_comb begin
        state_n       = state;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        resp_valid    = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_n = bad ? RESP : REQ;
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid || expired) begin
                    state_n = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Latch the request fields needed later for load extraction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lat_wen <= 1'b0;
            lat_f3  <= 3'b000;
            lat_off <= 2'b00;
        end else if (accept) begin
            lat_wen <= req_wen;
            lat_f3  <= req_funct3;
            lat_off <= req_addr[1:0];
        end
    end

    // Bus request registers; loaded only for legal accesses, then held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= 4'b0000;
            wen_q   <= 1'b0;
        end else if (accept && !bad) begin
            addr_q  <= {req_addr[WIDTH-1:2], 2'b00};
            wen_q   <= req_wen;
            wstrb_q <= req_wen ? st_strb : 4'b0000;
            wdata_q <= req_wen ? st_data : '0;
        end
    end

    // Wait-cycle counter, restarted when the bus takes the request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= 8'd0;
        end else if (state == REQ && mem_req_ready) begin
            cnt <= 8'd0;
        end else if (state == WAIT) begin
            cnt <= cnt + 8'd1;
        end
    end

    // Response registers; a bus response beats a same-cycle timeout.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept && bad) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
        end else if (state == WAIT) begin
            if (mem_resp_valid) begin
                rdata_q <= ld_data;
                err_q   <= mem_resp_err;
            end else if (expired) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25060166_lsu.sv
// tb_ysyx_25060166_lsu: scoreboard bench for the load/store unit.
// Expected responses are queued at issue and compared on resp_valid.
module tb_ysyx_25060166_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        mem_resp_err;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    ysyx_25060166_lsu dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_wen        (req_wen),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .mem_resp_err   (mem_resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_rdy"},   32'(req_ready), 32'd1);
        chk({tag, "_mrv"},   32'(mem_req_valid), 32'd0);
        chk({tag, "_rv"},    32'(resp_valid), 32'd0);
        chk({tag, "_rdata"}, resp_rdata, 32'd0);
        chk({tag, "_err"},   32'(resp_err), 32'd0);
        chk({tag, "_addr"},  mem_addr, 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_strb"},  32'(mem_wstrb), 32'd0);
        chk({tag, "_wen"},   32'(mem_wen), 32'd0);
    endtask

    // Wait up to hi cycles for resp_valid, then pop and compare.
    task automatic collect(input string tag, input int lo, input int hi);
        int   n;
        logic ok;
        exp_t e;
        n = 0;
        while (resp_valid !== 1'b1 && n <= hi) begin
            @(negedge clk);
            n++;
        end
        ok = (resp_valid === 1'b1) && (n >= lo) && (n <= hi);
        chk({tag, "_lat"}, 32'(ok), 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        if (resp_valid === 1'b1) begin
            chk({tag, "_rdata"}, resp_rdata, e.rdata);
            chk({tag, "_err"}, 32'(resp_err), 32'(e.err));
            @(negedge clk);
            chk({tag, "_pulse"}, 32'(resp_valid), 32'd0);
        end
    endtask

    // One access; rsp < 0 means the bus never answers.
    task automatic run(input string tag, input logic wen,
                       input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input int rdy,
                       input int rsp, input logic [31:0] word,
                       input logic berr, input logic [31:0] e_rdata,
                       input logic e_err, input logic bad,
                       input logic [3:0] e_strb,
                       input logic [31:0] e_wdata);
        exp_t        e;
        logic [31:0] e_addr;
        e_addr = {addr[31:2], 2'b00};
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        e.rdata = e_rdata;
        e.err   = e_err;
        sb.push_back(e);
        req_valid  = 1'b1;
        req_wen    = wen;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = $urandom;
        req_addr  = $urandom;
        if (bad) begin
            chk({tag, "_nobus"}, 32'(mem_req_valid), 32'd0);
            collect(tag, 0, 0);
            return;
        end
        chk({tag, "_mrv"},  32'(mem_req_valid), 32'd1);
        chk({tag, "_addr"}, mem_addr, e_addr);
        chk({tag, "_strb"}, 32'(mem_wstrb), 32'(e_strb));
        chk({tag, "_wen"},  32'(mem_wen), 32'(wen));
        if (wen) begin
            chk({tag, "_wdata"}, mem_wdata, e_wdata);
        end
        for (int i = 0; i < rdy; i++) begin
            @(negedge clk);
            chk({tag, "_stall_mrv"},  32'(mem_req_valid), 32'd1);
            chk({tag, "_stall_addr"}, mem_addr, e_addr);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        if (rsp < 0) begin
            collect(tag, 250, 260);
            return;
        end
        repeat (rsp) @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = word;
        mem_resp_err   = berr;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_resp_rdata = $urandom;
        mem_resp_err   = 1'b0;
        collect(tag, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=%08h exp=%08h", 32'd1, 32'd0);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst            = 1'b0;
        req_valid      = 1'b0;
        req_wen        = 1'b0;
        req_funct3     = 3'b000;
        req_addr       = '0;
        req_wdata      = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        mem_resp_err   = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        run("lw",  0, 3'b010, 32'h8000_0004, 32'h5555_5555, 0, 0,
            32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0, 0, 4'b0000, 0);
        run("lb",  0, 3'b000, 32'h8000_0003, 32'h1, 0, 0,
            32'h8011_2233, 0, 32'hFFFF_FF80, 0, 0, 4'b0000, 0);
        run("lbu", 0, 3'b100, 32'h8000_0003, 32'h1, 0, 0,
            32'h8011_2233, 0, 32'h0000_0080, 0, 0, 4'b0000, 0);
        run("lhu", 0, 3'b101, 32'h8000_0002, 32'h1, 0, 0,
            32'h8011_2233, 0, 32'h0000_8011, 0, 0, 4'b0000, 0);
        run("lh",  0, 3'b001, 32'h8000_0002, 32'h1, 0, 0,
            32'h8011_2233, 0, 32'hFFFF_8011, 0, 0, 4'b0000, 0);
        run("lb0", 0, 3'b000, 32'h0000_0040, 32'h1, 0, 1,
            32'h0000_007F, 0, 32'h0000_007F, 0, 0, 4'b0000, 0);
        run("sb",  1, 3'b000, 32'h0000_1001, 32'h0000_00AB, 0, 0,
            32'hFFFF_FFFF, 0, 32'h0, 0, 0, 4'b0010, 32'hABAB_ABAB);
        run("sh",  1, 3'b001, 32'h0000_1002, 32'h0000_1234, 0, 0,
            32'hFFFF_FFFF, 0, 32'h0, 0, 0, 4'b1100, 32'h1234_1234);
        run("sw",  1, 3'b010, 32'h0000_2000, 32'hCAFE_F00D, 1, 2,
            32'h1111_1111, 0, 32'h0, 0, 0, 4'b1111, 32'hCAFE_F00D);
        run("mis_lh", 0, 3'b001, 32'h0000_1001, 32'h0, 0, 0,
            32'h0, 0, 32'h0, 1, 1, 4'b0000, 0);
        run("st_f3_100", 1, 3'b100, 32'h0000_1000, 32'hFF, 0, 0,
            32'h0, 0, 32'h0, 1, 1, 4'b0000, 0);
        run("mis_lw", 0, 3'b010, 32'h0000_1002, 32'h0, 0, 0,
            32'h0, 0, 32'h0, 1, 1, 4'b0000, 0);
        run("ill_011", 0, 3'b011, 32'h0000_1000, 32'h0, 0, 0,
            32'h0, 0, 32'h0, 1, 1, 4'b0000, 0);
        run("stall", 0, 3'b010, 32'h0000_3008, 32'h0, 5, 3,
            32'h1234_5678, 0, 32'h1234_5678, 0, 0, 4'b0000, 0);
        run("tmo", 0, 3'b010, 32'h0000_300C, 32'h0, 0, -1,
            32'h0, 0, 32'h0, 1, 0, 4'b0000, 0);
        run("berr", 0, 3'b010, 32'h0000_3010, 32'h0, 0, 0,
            32'hFFFF_FFFF, 1, 32'h0, 1, 0, 4'b0000, 0);

        req_valid  = 1'b1;
        req_wen    = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_3000;
        @(negedge clk);
        req_valid     = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk_idle_zero("rst_wait");
        rst            = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'hA5A5_A5A5;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        chk("stray_rv0", 32'(resp_valid), 32'd0);
        chk("stray_rdy", 32'(req_ready), 32'd1);
        @(negedge clk);
        chk("stray_rv1", 32'(resp_valid), 32'd0);
        chk("sb_left", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
